// File: rtl/branch_ctrl.sv
// Branch controller: flag register, condition decode, IDLE/EVAL/FLUSH sequencing.
// Latency: accept -> pc_load in the following (EVAL) cycle; taken adds FLUSH_CYCLES flush cycles.
// Backpressure: br_ready only in IDLE; br_valid ignored otherwise, nothing is queued.
module branch_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flag_we,
    input  logic              alu_zero,
    input  logic              alu_ovf,
    input  logic              alu_minus,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    output logic              flush,
    output logic              stall,
    output logic              zf,
    output logic              vf,
    output logic              sf,
    output logic [7:0]        taken_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVAL  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    // Counter is loaded with the number of flush cycles still to go after the first one.
    localparam logic [3:0] FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cond_q;
    logic [ADDR_W-1:0] target_q;
    logic [3:0]        flush_cnt;
    logic              taken;

    // Flag register: written on any cycle with flag_we, in every state.
    always_ff @(posedge clk) begin
        if (rst) begin
            zf <= 1'b0;
            vf <= 1'b0;
            sf <= 1'b0;
        end else if (flag_we) begin
            zf <= alu_zero;
            vf <= alu_ovf;
            sf <= alu_minus;
        end
    end

    // Condition decode of the captured code against the registered flags.
    always_comb begin
        taken = 1'b0;
        case (cond_q)
            3'b000:  taken = zf;
            3'b001:  taken = sf ^ vf;
            3'b010:  taken = zf | (sf ^ vf);
            3'b011:  taken = ~zf;
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt = state;
        br_ready  = 1'b0;
        pc_load   = 1'b0;
        flush     = 1'b0;
        stall     = 1'b1;
        case (state)
            IDLE: begin
                br_ready = 1'b1;
                stall    = 1'b0;
                if (br_valid) begin
                    state_nxt = EVAL;
                end
            end
            EVAL: begin
                pc_load   = taken;
                state_nxt = taken ? FLUSH : IDLE;
            end
            FLUSH: begin
                flush = 1'b1;
                if (flush_cnt == 4'd0) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, flush down-counter and saturating taken counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_q    <= 3'd0;
            target_q  <= '0;
            flush_cnt <= 4'd0;
            taken_cnt <= 8'd0;
        end else begin
            if (state == IDLE && br_valid) begin
                cond_q   <= br_cond;
                target_q <= br_target;
            end
            if (state == EVAL && taken) begin
                flush_cnt <= FLUSH_LAST;
                if (taken_cnt != 8'hFF) begin
                    taken_cnt <= taken_cnt + 8'd1;
                end
            end else if (state == FLUSH && flush_cnt != 4'd0) begin
                flush_cnt <= flush_cnt - 4'd1;
            end
        end
    end

    assign pc_target = target_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed bench for branch_ctrl with FLUSH_CYCLES=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Each task checks its own scenario; summary line at the end.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_we;
    logic        alu_zero;
    logic        alu_ovf;
    logic        alu_minus;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [15:0] br_target;
    logic        br_ready;
    logic        pc_load;
    logic [15:0] pc_target;
    logic        flush;
    logic        stall;
    logic        zf;
    logic        vf;
    logic        sf;
    logic [7:0]  taken_cnt;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    branch_ctrl #(.ADDR_W(16), .FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .flag_we(flag_we),
        .alu_zero(alu_zero), .alu_ovf(alu_ovf), .alu_minus(alu_minus),
        .br_valid(br_valid), .br_cond(br_cond), .br_target(br_target),
        .br_ready(br_ready), .pc_load(pc_load), .pc_target(pc_target),
        .flush(flush), .stall(stall), .zf(zf), .vf(vf), .sf(sf),
        .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic z, input logic v, input logic s);
        flag_we = 1'b1; alu_zero = z; alu_ovf = v; alu_minus = s;
        tick();
        flag_we = 1'b0;
    endtask

    // Bounded wait for IDLE; expiry counts as a failure.
    task automatic wait_idle(input string name);
        int n = 0;
        while (br_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (br_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s: br_ready=%b after %0d cycles, required 1", name, br_ready, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if ({br_ready, pc_load, flush, stall} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_ctl: rdy/load/flush/stall=%b required 1000", {br_ready, pc_load, flush, stall});
        end
        tests++;
        if ({zf, vf, sf} !== 3'b000 || taken_cnt !== 8'd0 || pc_target !== 16'h0) begin
            fails++;
            $display("FAIL reset_regs: flags=%b cnt=%0d tgt=%h required 000/0/0000", {zf, vf, sf}, taken_cnt, pc_target);
        end
    endtask

    task automatic test_taken();
        set_flags(1'b1, 1'b0, 1'b0);
        br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h1234;
        tick();
        br_valid = 1'b0;
        tests++;
        if (pc_load !== 1'b1 || pc_target !== 16'h1234 || stall !== 1'b1 || br_ready !== 1'b0 || flush !== 1'b0) begin
            fails++;
            $display("FAIL taken_eval: load=%b tgt=%h stall=%b rdy=%b flush=%b required 1 1234 1 0 0", pc_load, pc_target, stall, br_ready, flush);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (flush !== 1'b1 || stall !== 1'b1 || pc_load !== 1'b0) begin
                fails++;
                $display("FAIL taken_flush%0d: flush=%b stall=%b load=%b required 1 1 0", i, flush, stall, pc_load);
            end
        end
        tick();
        exp_cnt = 1;
        tests++;
        if (flush !== 1'b0 || stall !== 1'b0 || br_ready !== 1'b1 || taken_cnt !== 8'(exp_cnt) || pc_target !== 16'h1234) begin
            fails++;
            $display("FAIL taken_done: flush=%b stall=%b rdy=%b cnt=%0d tgt=%h required 0 0 1 %0d 1234", flush, stall, br_ready, taken_cnt, exp_cnt, pc_target);
        end
    endtask

    task automatic test_not_taken();
        set_flags(1'b0, 1'b1, 1'b1);
        br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h5555;
        tick();
        br_valid = 1'b0;
        tests++;
        if (pc_load !== 1'b0 || stall !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL nt_eval: load=%b stall=%b flush=%b required 0 1 0", pc_load, stall, flush);
        end
        tick();
        tests++;
        if (br_ready !== 1'b1 || stall !== 1'b0 || flush !== 1'b0 || taken_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL nt_done: rdy=%b stall=%b flush=%b cnt=%0d required 1 0 0 %0d", br_ready, stall, flush, taken_cnt, exp_cnt);
        end
    endtask

    task automatic test_same_edge();
        // Z is 0 here; flag write and accept share an edge, EVAL must see Z=1.
        flag_we = 1'b1; alu_zero = 1'b1; alu_ovf = 1'b0; alu_minus = 1'b0;
        br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0BAD;
        tick();
        flag_we = 1'b0; br_valid = 1'b0;
        tests++;
        if (zf !== 1'b1 || pc_load !== 1'b0 || stall !== 1'b1) begin
            fails++;
            $display("FAIL same_edge: zf=%b load=%b stall=%b required 1 0 1", zf, pc_load, stall);
        end
        tick();
        tests++;
        if (br_ready !== 1'b1 || flush !== 1'b0) begin
            fails++;
            $display("FAIL same_edge_done: rdy=%b flush=%b required 1 0", br_ready, flush);
        end
    endtask

    task automatic run_table(input logic z, input logic v, input logic s, input logic [7:0] tab);
        set_flags(z, v, s);
        for (int c = 0; c < 8; c++) begin
            br_valid = 1'b1; br_cond = 3'(c); br_target = 16'hA000 + 16'(c);
            tick();
            br_valid = 1'b0;
            tests++;
            if (pc_load !== tab[c] || (tab[c] && pc_target !== 16'hA000 + 16'(c))) begin
                fails++;
                $display("FAIL decode z%b v%b s%b cond%0d: load=%b tgt=%h required %b", z, v, s, c, pc_load, pc_target, tab[c]);
            end
            if (tab[c]) exp_cnt++;
            wait_idle("decode_idle");
        end
        tests++;
        if (taken_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL decode_cnt: cnt=%0d required %0d", taken_cnt, exp_cnt);
        end
    endtask

    task automatic test_decode();
        logic [7:0] tab;
        tab = 8'b1000_1110;   // Z=0 S=1 V=0: LT, LE, NE, AL taken
        run_table(1'b0, 1'b0, 1'b1, tab);
        tab = 8'b1000_0101;   // Z=1 S=1 V=1: EQ, LE, AL taken
        run_table(1'b1, 1'b1, 1'b1, tab);
    endtask

    task automatic test_eval_flag_we();
        set_flags(1'b0, 1'b0, 1'b0);
        br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h7777;
        tick();
        br_valid = 1'b0;
        flag_we = 1'b1; alu_zero = 1'b1;
        tests++;
        if (pc_load !== 1'b0) begin
            fails++;
            $display("FAIL eval_we_load: load=%b required 0", pc_load);
        end
        tick();
        flag_we = 1'b0;
        tests++;
        if (br_ready !== 1'b1 || flush !== 1'b0 || zf !== 1'b1 || taken_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL eval_we_done: rdy=%b flush=%b zf=%b cnt=%0d required 1 0 1 %0d", br_ready, flush, zf, taken_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int evals[3];
        int n_eval = 0;
        int n = 0;
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'hBEEF;
        while (n_eval < 3 && n < 20) begin
            tick();
            if (pc_load === 1'b1) begin
                evals[n_eval] = n;
                n_eval++;
            end
            n++;
        end
        br_valid = 1'b0;
        tests++;
        if (n_eval != 3) begin
            fails++;
            $display("FAIL b2b_count: evals=%0d required 3", n_eval);
        end else begin
            // One accept cycle plus three stall cycles per taken branch.
            for (int i = 1; i < 3; i++) begin
                tests++;
                if (evals[i] - evals[i-1] != 4) begin
                    fails++;
                    $display("FAIL b2b_spacing%0d: %0d cycles required 4", i, evals[i] - evals[i-1]);
                end
            end
        end
        exp_cnt += 3;
        wait_idle("b2b_idle");
        tests++;
        if (taken_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL b2b_cnt: cnt=%0d required %0d", taken_cnt, exp_cnt);
        end
    endtask

    task automatic test_never();
        int loads = 0;
        int flushes = 0;
        int stalls = 0;
        br_valid = 1'b1; br_cond = 3'b100;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (pc_load === 1'b1) loads++;
            if (flush === 1'b1) flushes++;
            if (stall === 1'b1) stalls++;
        end
        br_valid = 1'b0;
        tick();
        tests++;
        if (loads != 0 || flushes != 0 || stalls != 4 || taken_cnt !== 8'(exp_cnt)) begin
            fails++;
            $display("FAIL never: loads=%0d flushes=%0d stalls=%0d cnt=%0d required 0 0 4 %0d", loads, flushes, stalls, taken_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid_flush();
        set_flags(1'b1, 1'b1, 1'b1);
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'hCAFE;
        tick();
        br_valid = 1'b0;
        tick();
        tests++;
        if (flush !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre: flush=%b required 1", flush);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 0;
        tests++;
        if (flush !== 1'b0 || stall !== 1'b0 || br_ready !== 1'b1 || {zf, vf, sf} !== 3'b000 || taken_cnt !== 8'd0) begin
            fails++;
            $display("FAIL rst_mid_flush: flush=%b stall=%b rdy=%b flags=%b cnt=%0d required 0 0 1 000 0", flush, stall, br_ready, {zf, vf, sf}, taken_cnt);
        end
        tick();
        tests++;
        if (flush !== 1'b0 || stall !== 1'b0) begin
            fails++;
            $display("FAIL rst_residual: flush=%b stall=%b required 0 0", flush, stall);
        end
    endtask

    task automatic test_saturate();
        int loads = 0;
        int n = 0;
        br_valid = 1'b1; br_cond = 3'b111; br_target = 16'h0042;
        while (loads < 300 && n < 1400) begin
            tick();
            if (pc_load === 1'b1) begin
                loads++;
                if (loads == 260) begin
                    tests++;
                    if (taken_cnt !== 8'd255) begin
                        fails++;
                        $display("FAIL sat_260: cnt=%0d required 255", taken_cnt);
                    end
                end
            end
            n++;
        end
        br_valid = 1'b0;
        wait_idle("sat_idle");
        tests++;
        if (loads != 300 || taken_cnt !== 8'd255) begin
            fails++;
            $display("FAIL sat_300: loads=%0d cnt=%0d required 300 255", loads, taken_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; flag_we = 1'b0; alu_zero = 1'b0; alu_ovf = 1'b0; alu_minus = 1'b0;
        br_valid = 1'b0; br_cond = 3'b000; br_target = 16'h0000;
        test_reset();
        test_taken();
        test_not_taken();
        test_same_edge();
        test_decode();
        test_eval_flag_we();
        test_back_to_back();
        test_never();
        test_reset_mid_flush();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
